// File: rtl/gem_tx_frame_sched.sv
// Frame-level round-robin scheduler feeding the GEM ext-FIFO TX path from NUM_PORTS AXIS sources.
// Optional mid-frame stall abort is compiled in with `define GEM_TX_SCHED_TIMEOUT_EN.
module gem_tx_frame_sched #(
    parameter int NUM_PORTS      = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_INFLIGHT   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    input  logic [NUM_PORTS-1:0]            s_axis_tuser,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tuser,
    input  logic                            m_axis_tready,
    input  logic                            gem_dma_tx_end_tog,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
    output logic [3:0]                      inflight,
    output logic                            abort_pulse
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    if (NUM_PORTS < 2 || NUM_PORTS > 8 || MAX_INFLIGHT < 1 || MAX_INFLIGHT > 15 ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("gem_tx_frame_sched: parameter out of range");
    end

`ifdef GEM_TX_SCHED_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_ABORT, S_DRAIN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_XFER} state_t;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_grant_id;
    logic [PTR_W-1:0]   w_pick;
    logic [3:0]         r_inflight;
    logic               r_tog_q;
    logic               w_grant_load;
    logic               w_rr_adv;
    logic               w_inc;
    logic               w_dec;
    logic               w_g_tvalid;
    logic               w_g_tlast;
    logic               w_g_tuser;
    logic [DATA_WIDTH-1:0] w_g_tdata;

    // First requesting port at or after ptr, wrapping.
    function automatic logic [PTR_W-1:0] f_rr_pick(input logic [PTR_W-1:0] ptr,
                                                   input logic [NUM_PORTS-1:0] req);
        logic [PTR_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
        return pick;
    endfunction

    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] g);
        return (int'(g) == NUM_PORTS - 1) ? '0 : g + PTR_W'(1);
    endfunction

    assign w_pick     = f_rr_pick(r_rr_ptr, s_axis_tvalid);
    assign w_g_tvalid = s_axis_tvalid[r_grant_id];
    assign w_g_tlast  = s_axis_tlast[r_grant_id];
    assign w_g_tuser  = s_axis_tuser[r_grant_id];
    assign w_g_tdata  = s_axis_tdata[r_grant_id*DATA_WIDTH +: DATA_WIDTH];

`ifdef GEM_TX_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_abort_pulse;
    logic             w_timeout;

    assign w_timeout = (r_state == S_XFER) && !w_g_tvalid &&
                       (r_stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt   <= '0;
            r_abort_pulse <= 1'b0;
        end else begin
            if (r_state == S_XFER && !w_g_tvalid)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            else
                r_stall_cnt <= '0;
            r_abort_pulse <= w_timeout;
        end
    end

    assign abort_pulse = r_abort_pulse;
`else
    assign abort_pulse = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_load  = 1'b0;
        w_rr_adv      = 1'b0;
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        m_axis_tdata  = '0;
        case (r_state)
            S_IDLE: begin
                if (|s_axis_tvalid && (r_inflight < 4'(MAX_INFLIGHT))) begin
                    w_grant_load = 1'b1;
                    w_state_nxt  = S_XFER;
                end
            end
            S_XFER: begin
                m_axis_tvalid             = w_g_tvalid;
                m_axis_tlast              = w_g_tlast;
                m_axis_tuser              = w_g_tuser;
                m_axis_tdata              = w_g_tdata;
                s_axis_tready[r_grant_id] = m_axis_tready;
                if (w_g_tvalid && m_axis_tready && w_g_tlast) begin
                    w_rr_adv    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
`ifdef GEM_TX_SCHED_TIMEOUT_EN
                else if (w_timeout) begin
                    w_state_nxt = S_ABORT;
                end
`endif
            end
`ifdef GEM_TX_SCHED_TIMEOUT_EN
            // Close the downstream frame as bad, then swallow the rest of the source frame.
            S_ABORT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
                if (m_axis_tready) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                s_axis_tready[r_grant_id] = 1'b1;
                if (w_g_tvalid && w_g_tlast) begin
                    w_rr_adv    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Every terminating beat handed downstream is a frame the GEM will later report as ended.
    assign w_inc = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign w_dec = gem_dma_tx_end_tog ^ r_tog_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_inflight <= '0;
            r_tog_q    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tog_q <= gem_dma_tx_end_tog;
            if (w_grant_load) r_grant_id <= w_pick;
            if (w_rr_adv)     r_rr_ptr   <= f_next_ptr(r_grant_id);
            if (w_inc && !w_dec)
                r_inflight <= r_inflight + 4'd1;
            else if (!w_inc && w_dec && r_inflight != 4'd0)
                r_inflight <= r_inflight - 4'd1;
        end
    end

    assign grant_id = r_grant_id;
    assign inflight = r_inflight;

endmodule

// File: tb/tb_gem_tx_frame_sched.sv
// Directed bench for gem_tx_frame_sched: vector table for round-robin order plus hand-written
// sequences for throttling, same-cycle completion, backpressure, reset and (with the macro) timeout.
module tb_gem_tx_frame_sched;

    localparam int NP = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic [NP*DW-1:0] s_tdata;
    logic [NP-1:0] s_tvalid, s_tlast, s_tuser, s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, m_tuser, m_tready;
    logic          tog;
    logic [1:0]    gid;
    logic [3:0]    infl;
    logic          abort;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int hs_base;

    gem_tx_frame_sched #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_INFLIGHT(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rstn(rstn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
        .gem_dma_tx_end_tog(tog), .grant_id(gid), .inflight(infl), .abort_pulse(abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rstn && m_tvalid && m_tready && m_tlast) hs_cnt <= hs_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  tv;
        logic [3:0]  tl;
        logic [31:0] td;
        logic        tg;
        logic        ev;
        logic        el;
        logic [7:0]  ed;
        logic [3:0]  er;
        logic [1:0]  eg;
        logic [3:0]  ei;
    } vec_t;

    vec_t vt[18];

    function automatic vec_t mk(input logic [3:0] tv, input logic [3:0] tl, input logic [31:0] td,
                                input logic tg, input logic ev, input logic el, input logic [7:0] ed,
                                input logic [3:0] er, input logic [1:0] eg, input logic [3:0] ei);
        vec_t v;
        v.tv = tv; v.tl = tl; v.td = td; v.tg = tg; v.ev = ev; v.el = el;
        v.ed = ed; v.er = er; v.eg = eg; v.ei = ei;
        return v;
    endfunction

    initial begin
        //          tv       tl       tdata         tog  v     l     data   rdy      gid   infl
        vt[0]  = mk(4'b1111, 4'b0000, 32'h30201000, 0,   0,    0,    8'h00, 4'b0000, 2'd0, 4'd0);
        vt[1]  = mk(4'b1111, 4'b0000, 32'h30201000, 0,   1,    0,    8'h00, 4'b0001, 2'd0, 4'd0);
        vt[2]  = mk(4'b1111, 4'b0000, 32'h30201001, 0,   1,    0,    8'h01, 4'b0001, 2'd0, 4'd0);
        vt[3]  = mk(4'b1111, 4'b0001, 32'h30201002, 0,   1,    1,    8'h02, 4'b0001, 2'd0, 4'd0);
        vt[4]  = mk(4'b1110, 4'b0000, 32'h30201000, 1,   0,    0,    8'h00, 4'b0000, 2'd0, 4'd1);
        vt[5]  = mk(4'b1110, 4'b0000, 32'h30201000, 1,   1,    0,    8'h10, 4'b0010, 2'd1, 4'd0);
        vt[6]  = mk(4'b1110, 4'b0000, 32'h30201100, 1,   1,    0,    8'h11, 4'b0010, 2'd1, 4'd0);
        vt[7]  = mk(4'b1110, 4'b0010, 32'h30201200, 1,   1,    1,    8'h12, 4'b0010, 2'd1, 4'd0);
        vt[8]  = mk(4'b1100, 4'b0000, 32'h30200000, 0,   0,    0,    8'h00, 4'b0000, 2'd1, 4'd1);
        vt[9]  = mk(4'b1100, 4'b0000, 32'h30200000, 0,   1,    0,    8'h20, 4'b0100, 2'd2, 4'd0);
        vt[10] = mk(4'b1100, 4'b0000, 32'h30210000, 0,   1,    0,    8'h21, 4'b0100, 2'd2, 4'd0);
        vt[11] = mk(4'b1100, 4'b0100, 32'h30220000, 0,   1,    1,    8'h22, 4'b0100, 2'd2, 4'd0);
        vt[12] = mk(4'b1000, 4'b0000, 32'h30000000, 1,   0,    0,    8'h00, 4'b0000, 2'd2, 4'd1);
        vt[13] = mk(4'b1000, 4'b0000, 32'h30000000, 1,   1,    0,    8'h30, 4'b1000, 2'd3, 4'd0);
        vt[14] = mk(4'b1000, 4'b0000, 32'h31000000, 1,   1,    0,    8'h31, 4'b1000, 2'd3, 4'd0);
        vt[15] = mk(4'b1000, 4'b1000, 32'h32000000, 1,   1,    1,    8'h32, 4'b1000, 2'd3, 4'd0);
        vt[16] = mk(4'b0000, 4'b0000, 32'h00000000, 0,   0,    0,    8'h00, 4'b0000, 2'd3, 4'd1);
        vt[17] = mk(4'b0000, 4'b0000, 32'h00000000, 0,   0,    0,    8'h00, 4'b0000, 2'd3, 4'd0);

        rstn = 1'b0; s_tdata = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
        m_tready = 1'b1; tog = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {m_tvalid, m_tlast, m_tuser, m_tdata, s_tready, gid, infl, abort}, '0);
        @(negedge clk) rstn = 1'b1;

        // Round-robin over four 3-beat frames with a completion after each
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            s_tvalid = vt[i].tv; s_tlast = vt[i].tl; s_tdata = vt[i].td; tog = vt[i].tg;
            #1;
            check($sformatf("vec[%0d]", i),
                  {m_tvalid, m_tlast, m_tuser, m_tdata, s_tready, gid, infl},
                  {vt[i].ev, vt[i].el, 1'b0, vt[i].ed, vt[i].er, vt[i].eg, vt[i].ei});
        end

        // Throttle: single-beat frames on every port, no completions
        @(negedge clk);
        hs_base = hs_cnt;
        s_tvalid = 4'b1111; s_tlast = 4'b1111; s_tdata = 32'h33221100;
        repeat (8) @(negedge clk);
        #1;
        check("throttle_frames", hs_cnt - hs_base, 2);
        check("throttle_inflight", infl, 4'd2);
        check("throttle_ready", {s_tready, m_tvalid}, 5'b0);
        check("throttle_gid", gid, 2'd1);
        tog = 1'b1;
        @(negedge clk); #1;
        check("release_wait", {m_tvalid, infl}, {1'b0, 4'd1});
        @(negedge clk); #1;
        check("release_grant", {m_tvalid, gid, m_tdata}, {1'b1, 2'd2, 8'h22});
        @(negedge clk);
        s_tvalid = '0; s_tlast = '0;
        #1;
        check("release_inflight", infl, 4'd2);

        // Completion and tlast handshake in the same cycle at inflight=1
        tog = 1'b0;
        @(negedge clk); #1;
        check("pre_same_inflight", infl, 4'd1);
        s_tvalid = 4'b1000; s_tlast = 4'b1000; s_tdata = 32'h33000000;
        @(negedge clk); #1;
        check("same_grant", {m_tvalid, m_tlast, gid}, {1'b1, 1'b1, 2'd3});
        tog = 1'b1;
        @(negedge clk);

        // Port 2 single-beat bad frame under toggling backpressure
        hs_base = hs_cnt;
        s_tvalid = 4'b0100; s_tlast = 4'b0100; s_tuser = 4'b0100; s_tdata = 32'h00A50000;
        m_tready = 1'b1;
        #1;
        check("same_inflight", infl, 4'd1);
        check("bp_idle_ready", s_tready, 4'b0000);
        @(negedge clk);
        m_tready = 1'b0;
        #1;
        check("bp_hold", {m_tvalid, m_tlast, m_tuser, m_tdata, s_tready}, {3'b111, 8'hA5, 4'b0000});
        @(negedge clk);
        m_tready = 1'b1;
        #1;
        check("bp_ready", {m_tvalid, s_tready}, {1'b1, 4'b0100});
        @(negedge clk);
        m_tready = 1'b0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
        #1;
        check("bp_done", {m_tvalid, s_tready, infl}, {1'b0, 4'b0000, 4'd2});
        check("bp_once", hs_cnt - hs_base, 1);
        m_tready = 1'b1;

        // Completions down to zero, then one more that must be ignored
        @(negedge clk) tog = 1'b0;
        @(negedge clk); #1;
        check("dec_to_1", infl, 4'd1);
        tog = 1'b1;
        @(negedge clk); #1;
        check("dec_to_0", infl, 4'd0);
        tog = 1'b0;
        @(negedge clk); #1;
        check("dec_sat_0", infl, 4'd0);

        // Asynchronous reset in the middle of a port 3 frame
        @(negedge clk);
        s_tvalid = 4'b1000; s_tlast = 4'b0000; s_tdata = 32'h77000000;
        @(negedge clk); #1;
        check("pre_reset_xfer", {m_tvalid, gid, s_tready, m_tdata}, {1'b1, 2'd3, 4'b1000, 8'h77});
        #2 rstn = 1'b0;
        #1;
        check("async_reset", {m_tvalid, m_tlast, m_tuser, m_tdata, s_tready, gid, infl, abort}, '0);
        s_tvalid = '0;
        @(negedge clk) rstn = 1'b1;

`ifdef GEM_TX_SCHED_TIMEOUT_EN
        // Port 1 stalls mid-frame long enough to be aborted; port 2 is waiting
        @(negedge clk);
        s_tvalid = 4'b0110; s_tlast = 4'b0100; s_tdata = 32'h00201000;
        @(negedge clk); #1;
        check("to_grant", {m_tvalid, gid, m_tdata}, {1'b1, 2'd1, 8'h10});
        @(negedge clk) s_tdata = 32'h00201100;
        @(negedge clk) s_tvalid = 4'b0100;
        repeat (7) @(negedge clk);
        #1;
        check("to_before", {abort, m_tvalid}, 2'b00);
        @(negedge clk); #1;
        check("to_abort", {abort, m_tvalid, m_tlast, m_tuser, m_tdata, s_tready},
              {4'b1111, 8'h00, 4'b0000});
        @(negedge clk);
        s_tvalid = 4'b0110; s_tdata = 32'h00201200;
        #1;
        check("drain_0", {abort, m_tvalid, s_tready, infl}, {2'b00, 4'b0010, 4'd1});
        @(negedge clk) s_tdata = 32'h00201300;
        #1;
        check("drain_1", {m_tvalid, s_tready}, {1'b0, 4'b0010});
        @(negedge clk);
        s_tdata = 32'h00201400; s_tlast = 4'b0110;
        #1;
        check("drain_2", {m_tvalid, s_tready}, {1'b0, 4'b0010});
        @(negedge clk);
        s_tvalid = 4'b0100; s_tlast = 4'b0100; s_tdata = 32'h00200000;
        #1;
        check("after_drain_idle", m_tvalid, 1'b0);
        @(negedge clk); #1;
        check("after_drain_grant", {m_tvalid, gid, m_tdata, infl}, {1'b1, 2'd2, 8'h20, 4'd1});
        @(negedge clk) s_tvalid = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
